// File: rtl/spectro_fifo_writer.sv
// -----------------------------------------------------------------------------
// spectro_fifo_writer
//
// Producer side of the four spectrometer channel FIFOs. A raster stream of
// 10-bit pixels is split, one row at a time, across channels 0-3 in the
// interleaved kernel order that the binning block expects on the read side.
//
// Column col is split into group g = col/8 and offset o = col%8. Offsets
// 2k and 2k+1 form a pair, and both pixels of a pair go to the same channel:
//   even group : channel k,     written in ascending order  (o=2k, then 2k+1)
//   odd group  : channel 3-k,   written in descending order (o=2k+1, then 2k)
// This way every channel receives exactly two words per group.
//
// Ports
//   clk                        single clock domain
//   RST                        synchronous, active-high reset
//   pix_data / pix_valid       pixel sample and its valid strobe
//   pix_sol                    start-of-line, only meaningful on a valid beat
//   pix_ready                  block accepts a pixel this cycle
//   spectroChannelN_DATA       write data to FIFO N (held when not writing)
//   spectroChannelN_FIFO_WR    write strobe to FIFO N
//   spectroChannelN_FIFO_FULL  FIFO N full, suppresses writes to it
//   row_count                  completed rows, wraps modulo 2^ROW_CNT_W
//   sync_err                   one-cycle pulse on a misplaced start-of-line
// -----------------------------------------------------------------------------
module spectro_fifo_writer #(
  parameter int ROW_PIXELS = 1280,
  parameter int ROW_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [9:0]           pix_data,
  input  logic                 pix_valid,
  input  logic                 pix_sol,
  output logic                 pix_ready,
  output logic [9:0]           spectroChannel0_DATA,
  output logic                 spectroChannel0_FIFO_WR,
  input  logic                 spectroChannel0_FIFO_FULL,
  output logic [9:0]           spectroChannel1_DATA,
  output logic                 spectroChannel1_FIFO_WR,
  input  logic                 spectroChannel1_FIFO_FULL,
  output logic [9:0]           spectroChannel2_DATA,
  output logic                 spectroChannel2_FIFO_WR,
  input  logic                 spectroChannel2_FIFO_FULL,
  output logic [9:0]           spectroChannel3_DATA,
  output logic                 spectroChannel3_FIFO_WR,
  input  logic                 spectroChannel3_FIFO_FULL,
  output logic [ROW_CNT_W-1:0] row_count,
  output logic                 sync_err
);

  // One extra bit so that bit 3 (group parity) exists even for 8-pixel rows.
  localparam int               COL_W    = $clog2(ROW_PIXELS) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_PIXELS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  typedef enum logic [1:0] {
    S_FIRST,
    S_SECOND,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [9:0]           hold_q, hold_d;
  logic [9:0]           pend_q, pend_d;
  logic [1:0]           pendCh_q, pendCh_d;
  logic [ROW_CNT_W-1:0] rowCount_q, rowCount_d;
  logic                 syncErr_q, syncErr_d;
  logic [3:0][9:0]      dataLast_q, dataLast_d;

  logic [3:0]       full;
  logic [3:0]       wrEn;
  logic [9:0]       wrData;
  logic             ready;
  logic             accept;
  logic             misSol;
  logic             oddGroup;
  logic [1:0]       pairIdx;
  logic [1:0]       pairCh;
  logic [COL_W-1:0] colInc;

  assign full = {spectroChannel3_FIFO_FULL, spectroChannel2_FIFO_FULL,
                 spectroChannel1_FIFO_FULL, spectroChannel0_FIFO_FULL};

  // Group parity and pair index come straight from the column bits; in
  // S_SECOND col_q addresses the second pixel, which shares both with the
  // first pixel of its pair.
  assign oddGroup = col_q[3];
  assign pairIdx  = col_q[2:1];
  assign pairCh   = oddGroup ? (2'd3 - pairIdx) : pairIdx;
  assign colInc   = (col_q == COL_LAST) ? '0 : col_q + COL_ONE;

  // A start-of-line away from column 0 restarts the row.
  assign misSol   = pix_valid && pix_sol && (col_q != '0);

  // Next-state and write decode. Writes are combinational so that the first
  // word of a pair leaves in the same cycle its second pixel is accepted.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    pendCh_d   = pendCh_q;
    rowCount_d = rowCount_q;
    syncErr_d  = 1'b0;
    dataLast_d = dataLast_q;
    wrEn       = 4'b0000;
    wrData     = '0;
    ready      = 1'b0;

    unique case (state_q)
      S_FIRST:  ready = 1'b1;
      // A restart never writes, so it is not gated by the pair channel.
      S_SECOND: ready = misSol || !full[pairCh];
      S_DRAIN:  ready = !full[pendCh_q];
      default:  ready = 1'b0;
    endcase

    accept = pix_valid && ready;

    unique case (state_q)
      S_FIRST: begin
        if (accept) begin
          hold_d    = pix_data;
          col_d     = misSol ? COL_ONE : colInc;
          syncErr_d = misSol;
          state_d   = S_SECOND;
        end
      end

      S_SECOND: begin
        if (accept) begin
          if (misSol) begin
            // Unpaired hold is dropped; this pixel becomes column 0.
            hold_d    = pix_data;
            col_d     = COL_ONE;
            syncErr_d = 1'b1;
          end else begin
            wrEn[pairCh] = 1'b1;
            wrData       = oddGroup ? pix_data : hold_q;
            pend_d       = oddGroup ? hold_q : pix_data;
            pendCh_d     = pairCh;
            col_d        = colInc;
            if (col_q == COL_LAST) begin
              rowCount_d = rowCount_q + 1'b1;
            end
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // The pending word drains while the next first-of-pair is taken.
        if (!full[pendCh_q]) begin
          wrEn[pendCh_q] = 1'b1;
          wrData         = pend_q;
          if (accept) begin
            hold_d    = pix_data;
            col_d     = misSol ? COL_ONE : colInc;
            syncErr_d = misSol;
            state_d   = S_SECOND;
          end else begin
            state_d = S_FIRST;
          end
        end
      end

      default: state_d = S_FIRST;
    endcase

    for (int c = 0; c < 4; c++) begin
      if (wrEn[c]) begin
        dataLast_d[c] = wrData;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_FIRST;
      col_q      <= '0;
      hold_q     <= '0;
      pend_q     <= '0;
      pendCh_q   <= '0;
      rowCount_q <= '0;
      syncErr_q  <= 1'b0;
      dataLast_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pendCh_q   <= pendCh_d;
      rowCount_q <= rowCount_d;
      syncErr_q  <= syncErr_d;
      dataLast_q <= dataLast_d;
    end
  end

  // Handshake and FIFO outputs are forced quiet for the whole reset cycle.
  assign pix_ready = ready && !RST;

  assign spectroChannel0_FIFO_WR = wrEn[0] && !RST;
  assign spectroChannel1_FIFO_WR = wrEn[1] && !RST;
  assign spectroChannel2_FIFO_WR = wrEn[2] && !RST;
  assign spectroChannel3_FIFO_WR = wrEn[3] && !RST;

  assign spectroChannel0_DATA = RST ? '0 : (wrEn[0] ? wrData : dataLast_q[0]);
  assign spectroChannel1_DATA = RST ? '0 : (wrEn[1] ? wrData : dataLast_q[1]);
  assign spectroChannel2_DATA = RST ? '0 : (wrEn[2] ? wrData : dataLast_q[2]);
  assign spectroChannel3_DATA = RST ? '0 : (wrEn[3] ? wrData : dataLast_q[3]);

  assign row_count = rowCount_q;
  assign sync_err  = syncErr_q;

endmodule

// File: tb/tb_spectro_fifo_writer.sv
// -----------------------------------------------------------------------------
// tb_spectro_fifo_writer
//
// Self-checking bench for spectro_fifo_writer with 16-pixel rows. Every cycle
// goes through applyStimulus, which drives inputs on the falling edge, samples
// outputs shortly before the rising edge, logs FIFO writes per channel and
// feeds accepted pixels to a pair-level reference model of the channel order.
// -----------------------------------------------------------------------------
module tb_spectro_fifo_writer;

  localparam int ROWPIX = 16;
  localparam int RCW    = 16;

  logic           clk = 1'b0;
  logic           RST = 1'b1;
  logic [9:0]     pix_data = '0;
  logic           pix_valid = 1'b0;
  logic           pix_sol = 1'b0;
  logic           pix_ready;
  logic [9:0]     d0, d1, d2, d3;
  logic           wr0, wr1, wr2, wr3;
  logic           f0 = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic [RCW-1:0] row_count;
  logic           sync_err;

  always #5 clk = ~clk;

  spectro_fifo_writer #(
    .ROW_PIXELS(ROWPIX),
    .ROW_CNT_W (RCW)
  ) dut (
    .clk                      (clk),
    .RST                      (RST),
    .pix_data                 (pix_data),
    .pix_valid                (pix_valid),
    .pix_sol                  (pix_sol),
    .pix_ready                (pix_ready),
    .spectroChannel0_DATA     (d0),
    .spectroChannel0_FIFO_WR  (wr0),
    .spectroChannel0_FIFO_FULL(f0),
    .spectroChannel1_DATA     (d1),
    .spectroChannel1_FIFO_WR  (wr1),
    .spectroChannel1_FIFO_FULL(f1),
    .spectroChannel2_DATA     (d2),
    .spectroChannel2_FIFO_WR  (wr2),
    .spectroChannel2_FIFO_FULL(f2),
    .spectroChannel3_DATA     (d3),
    .spectroChannel3_FIFO_WR  (wr3),
    .spectroChannel3_FIFO_FULL(f3),
    .row_count                (row_count),
    .sync_err                 (sync_err)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int fullFrom[4] = '{0, 0, 0, 0};
  int fullTo[4]   = '{0, 0, 0, 0};
  int randFullPct = 0;
  logic rstReq    = 1'b1;

  logic       sReady;
  logic [3:0] sWr;
  logic [9:0] sData[4];
  logic [9:0] lastW[4] = '{10'd0, 10'd0, 10'd0, 10'd0};
  int         seenSync = 0;

  // Reference model state: column of the next accepted pixel, the waiting
  // first pixel of a pair, completed rows and expected restarts.
  int         mCol = 0;
  bit         mHave = 1'b0;
  logic [9:0] mFirst = '0;
  int         mFirstCol = 0;
  int         mRows = 0;
  int         mSyncErrs = 0;
  logic [9:0] expQ[4][$];
  logic [9:0] actQ[4][$];

  task automatic clearScoreboard();
    for (int c = 0; c < 4; c++) begin
      expQ[c].delete();
      actQ[c].delete();
    end
  endtask

  // One clock cycle: drive, sample, protocol checks, model update.
  task automatic applyStimulus(input bit v, input logic [9:0] d, input bit s);
    logic [3:0] fullV;
    int g, k, ch;
    @(negedge clk);
    cyc++;
    RST       = rstReq;
    pix_valid = v;
    pix_data  = d;
    pix_sol   = s;
    for (int c = 0; c < 4; c++) begin
      fullV[c] = (cyc >= fullFrom[c] && cyc < fullTo[c]) ||
                 (int'($urandom_range(0, 99)) < randFullPct);
    end
    {f3, f2, f1, f0} = fullV;
    #3;
    sReady   = pix_ready;
    sWr      = {wr3, wr2, wr1, wr0};
    sData[0] = d0;
    sData[1] = d1;
    sData[2] = d2;
    sData[3] = d3;
    if (sync_err === 1'b1) seenSync++;

    testsRun++;
    if ((sWr & fullV) !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL wr_while_full: wr=%b full=%b required no overlap", sWr, fullV);
    end
    testsRun++;
    if ($countones(sWr) > 1) begin
      testsFailed++;
      $display("[TB] FAIL one_write_per_cycle: wr=%b required at most one bit", sWr);
    end

    if (RST) begin
      testsRun++;
      if (sWr !== 4'b0000 || sReady !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL quiet_in_reset: wr=%b ready=%b required 0000/0", sWr, sReady);
      end
      for (int c = 0; c < 4; c++) lastW[c] = '0;
      mCol  = 0;
      mHave = 1'b0;
      mRows = 0;
    end

    for (int c = 0; c < 4; c++) begin
      if (sWr[c] === 1'b1) begin
        actQ[c].push_back(sData[c]);
        lastW[c] = sData[c];
      end else begin
        testsRun++;
        if (sData[c] !== lastW[c]) begin
          testsFailed++;
          $display("[TB] FAIL data_hold ch%0d: got %0h required %0h", c, sData[c], lastW[c]);
        end
      end
    end

    if (!RST && v && sReady === 1'b1) begin
      if (s && mCol != 0) begin
        mSyncErrs++;
        mCol  = 0;
        mHave = 1'b0;
      end
      if (!mHave) begin
        mFirst    = d;
        mFirstCol = mCol;
        mHave     = 1'b1;
      end else begin
        g  = mFirstCol / 8;
        k  = (mFirstCol % 8) / 2;
        ch = (g % 2 == 1) ? 3 - k : k;
        if (g % 2 == 0) begin
          expQ[ch].push_back(mFirst);
          expQ[ch].push_back(d);
        end else begin
          expQ[ch].push_back(d);
          expQ[ch].push_back(mFirst);
        end
        mHave = 1'b0;
      end
      mCol++;
      if (mCol == ROWPIX) begin
        mCol = 0;
        mRows++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 10'd0, 1'b0);
  endtask

  // Hold a pixel valid until accepted; reports cycles spent stalled.
  task automatic sendPixel(input logic [9:0] d, input bit s, output int stalls);
    bit done;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      applyStimulus(1'b1, d, s);
      if (sReady === 1'b1) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: pixel %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    applyStimulus(1'b0, 10'd0, 1'b0);
    rstReq = 1'b0;
    idle(1);
    clearScoreboard();
  endtask

  task automatic test_reset();
    rstReq = 1'b1;
    idle(2);
    testsRun++;
    if (sReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b required 0", sReady);
    end
    testsRun++;
    if ({sData[3], sData[2], sData[1], sData[0]} !== 40'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got %0h %0h %0h %0h required 0", sData[0], sData[1], sData[2], sData[3]);
    end
    testsRun++;
    if (row_count !== '0 || sync_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: row_count=%0d sync_err=%b required 0/0", row_count, sync_err);
    end
    rstReq = 1'b0;
    idle(1);
    clearScoreboard();
  endtask

  task automatic test_basic_row();
    int want[4][4] = '{'{0, 1, 15, 14}, '{2, 3, 13, 12}, '{4, 5, 11, 10}, '{6, 7, 9, 8}};
    int st, totalStalls;
    totalStalls = 0;
    for (int v = 0; v < ROWPIX; v++) begin
      sendPixel(10'(v), v == 0, st);
      totalStalls += st;
    end
    testsRun++;
    if (totalStalls != 0) begin
      testsFailed++;
      $display("[TB] FAIL basic_ready: stalls=%0d required 0", totalStalls);
    end
    idle(1);
    testsRun++;
    if (sWr !== 4'b0001 || sData[0] !== 10'd14) begin
      testsFailed++;
      $display("[TB] FAIL basic_last_write: wr=%b data=%0d required 0001/14", sWr, sData[0]);
    end
    testsRun++;
    if (row_count !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL basic_row_count: got %0d required 1", row_count);
    end
    idle(1);
    testsRun++;
    if (sWr !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL basic_no_extra_write: wr=%b required 0000", sWr);
    end
    for (int c = 0; c < 4; c++) begin
      testsRun++;
      if (actQ[c].size() != 4) begin
        testsFailed++;
        $display("[TB] FAIL basic_count ch%0d: got %0d words required 4", c, actQ[c].size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          testsRun++;
          if (actQ[c][i] !== 10'(want[c][i])) begin
            testsFailed++;
            $display("[TB] FAIL basic_order ch%0d[%0d]: got %0d required %0d", c, i, actQ[c][i], want[c][i]);
          end
        end
      end
    end
    clearScoreboard();
  endtask

  task automatic test_full_stall();
    int want[4][4] = '{'{0, 1, 15, 14}, '{2, 3, 13, 12}, '{4, 5, 11, 10}, '{6, 7, 9, 8}};
    int st;
    for (int v = 0; v < ROWPIX; v++) begin
      if (v == 3) begin
        fullFrom[1] = cyc + 1;
        fullTo[1]   = cyc + 6;
      end
      sendPixel(10'(v), v == 0, st);
      if (v == 3) begin
        testsRun++;
        if (st != 5) begin
          testsFailed++;
          $display("[TB] FAIL ch1_stall_len: got %0d stalled cycles required 5", st);
        end
      end
      if (v == 9) begin
        fullFrom[3] = cyc + 1;
        fullTo[3]   = cyc + 4;
      end
      if (v == 10) begin
        testsRun++;
        if (st != 3) begin
          testsFailed++;
          $display("[TB] FAIL ch3_drain_stall_len: got %0d stalled cycles required 3", st);
        end
      end
    end
    idle(2);
    for (int c = 0; c < 4; c++) begin
      testsRun++;
      if (actQ[c].size() != 4) begin
        testsFailed++;
        $display("[TB] FAIL stall_count ch%0d: got %0d words required 4", c, actQ[c].size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          testsRun++;
          if (actQ[c][i] !== 10'(want[c][i])) begin
            testsFailed++;
            $display("[TB] FAIL stall_order ch%0d[%0d]: got %0d required %0d", c, i, actQ[c][i], want[c][i]);
          end
        end
      end
    end
    clearScoreboard();
  endtask

  task automatic test_back_to_back_rows();
    int want[4][4] = '{'{0, 1, 15, 14}, '{2, 3, 13, 12}, '{4, 5, 11, 10}, '{6, 7, 9, 8}};
    int st;
    doReset();
    for (int v = 0; v < ROWPIX; v++) sendPixel(10'(v), v == 0, st);
    for (int v = 0; v < ROWPIX; v++) sendPixel(10'(100 + v), v == 0, st);
    idle(2);
    testsRun++;
    if (row_count !== 16'd2) begin
      testsFailed++;
      $display("[TB] FAIL two_rows_count: got %0d required 2", row_count);
    end
    for (int c = 0; c < 4; c++) begin
      testsRun++;
      if (actQ[c].size() != 8) begin
        testsFailed++;
        $display("[TB] FAIL two_rows_words ch%0d: got %0d required 8", c, actQ[c].size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          testsRun++;
          if (actQ[c][i] !== 10'(want[c][i % 4] + (i >= 4 ? 100 : 0))) begin
            testsFailed++;
            $display("[TB] FAIL two_rows_order ch%0d[%0d]: got %0d required %0d", c, i, actQ[c][i],
                     want[c][i % 4] + (i >= 4 ? 100 : 0));
          end
        end
      end
    end
    clearScoreboard();
  endtask

  task automatic test_sol_mid_row();
    int st, syncBefore;
    bit sawFour;
    doReset();
    syncBefore = seenSync;
    for (int v = 0; v < 5; v++) sendPixel(10'(v), v == 0, st);
    sendPixel(10'd5, 1'b1, st);
    for (int v = 6; v <= 20; v++) sendPixel(10'(v), 1'b0, st);
    idle(3);
    testsRun++;
    if (seenSync - syncBefore != 1) begin
      testsFailed++;
      $display("[TB] FAIL sol_sync_pulse: got %0d high cycles required 1", seenSync - syncBefore);
    end
    testsRun++;
    if (actQ[1].size() < 2 || actQ[1][0] !== 10'd2 || actQ[1][1] !== 10'd3) begin
      testsFailed++;
      $display("[TB] FAIL sol_pend_drained: ch1 size=%0d required to start 2,3", actQ[1].size());
    end
    testsRun++;
    if (actQ[0].size() < 4 || actQ[0][0] !== 10'd0 || actQ[0][1] !== 10'd1 ||
        actQ[0][2] !== 10'd5 || actQ[0][3] !== 10'd6) begin
      testsFailed++;
      $display("[TB] FAIL sol_restart_pair: ch0 size=%0d required to start 0,1,5,6", actQ[0].size());
    end
    sawFour = 1'b0;
    for (int c = 0; c < 4; c++)
      foreach (actQ[c][i]) if (actQ[c][i] === 10'd4) sawFour = 1'b1;
    testsRun++;
    if (sawFour) begin
      testsFailed++;
      $display("[TB] FAIL sol_hold_dropped: pixel 4 written, required dropped");
    end
    testsRun++;
    if (row_count !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL sol_row_count: got %0d required 1", row_count);
    end
    for (int c = 0; c < 4; c++) begin
      testsRun++;
      if (actQ[c] != expQ[c]) begin
        testsFailed++;
        $display("[TB] FAIL sol_model ch%0d: got %0d words required %0d", c, actQ[c].size(), expQ[c].size());
      end
    end
    clearScoreboard();
  endtask

  task automatic test_reset_midpair();
    int st;
    doReset();
    sendPixel(10'h2AA, 1'b1, st);
    rstReq = 1'b1;
    idle(1);
    rstReq = 1'b0;
    clearScoreboard();
    idle(3);
    testsRun++;
    if (actQ[0].size() + actQ[1].size() + actQ[2].size() + actQ[3].size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL rst_no_write: got writes after reset required none");
    end
    testsRun++;
    if (row_count !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL rst_row_count: got %0d required 0", row_count);
    end
    sendPixel(10'h001, 1'b1, st);
    sendPixel(10'h002, 1'b0, st);
    idle(2);
    testsRun++;
    if (actQ[0].size() != 2 || actQ[0][0] !== 10'h001 || actQ[0][1] !== 10'h002) begin
      testsFailed++;
      $display("[TB] FAIL rst_first_pair: ch0 size=%0d required 001,002", actQ[0].size());
    end
    clearScoreboard();
  endtask

  task automatic test_random();
    int syncBefore, st;
    bit s;
    doReset();
    syncBefore  = seenSync;
    mSyncErrs   = 0;
    randFullPct = 25;
    for (int i = 0; i < 700; i++) begin
      s = (mCol == 0) ? 1'b1 : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      else sendPixel(10'($urandom), s, st);
    end
    randFullPct = 0;
    idle(4);
    for (int c = 0; c < 4; c++) begin
      testsRun++;
      if (actQ[c].size() != expQ[c].size()) begin
        testsFailed++;
        $display("[TB] FAIL rand_count ch%0d: got %0d words required %0d", c, actQ[c].size(), expQ[c].size());
      end else begin
        for (int i = 0; i < expQ[c].size(); i++) begin
          testsRun++;
          if (actQ[c][i] !== expQ[c][i]) begin
            testsFailed++;
            $display("[TB] FAIL rand_order ch%0d[%0d]: got %0h required %0h", c, i, actQ[c][i], expQ[c][i]);
          end
        end
      end
    end
    testsRun++;
    if (row_count !== RCW'(mRows)) begin
      testsFailed++;
      $display("[TB] FAIL rand_row_count: got %0d required %0d", row_count, mRows);
    end
    testsRun++;
    if (seenSync - syncBefore != mSyncErrs) begin
      testsFailed++;
      $display("[TB] FAIL rand_sync_err: got %0d pulses required %0d", seenSync - syncBefore, mSyncErrs);
    end
    clearScoreboard();
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_full_stall();
    test_back_to_back_rows();
    test_sol_mid_row();
    test_reset_midpair();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
